// File: rtl/instr_loader_if.sv
// instr_loader_if
// Bundles the loader's byte-stream handshake, instruction-memory write port
// and CPU control/status lines.
//   start, byte_valid, byte_data   : stream side, driven by the byte source
//   byte_ready                     : loader accepts byte_data this cycle
//   wr_en, wr_addr, wr_data        : instruction-memory write port
//   cpu_hold, cpu_rst_pulse        : CPU control
//   load_done, load_err            : sticky load status
// modport slave is the loader; modport master is the source/observer side.
interface instr_loader_if #(
   parameter int ADDR_W = 5
);
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [19:0]       wr_data;
   logic              cpu_hold;
   logic              cpu_rst_pulse;
   logic              load_done;
   logic              load_err;

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data,
      output cpu_hold, cpu_rst_pulse, load_done, load_err
   );

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data,
      input  cpu_hold, cpu_rst_pulse, load_done, load_err
   );
endinterface

// File: rtl/instr_loader.sv
// instr_loader
// Program loader feeding the instruction memory. Accepts a framed byte stream
// (COUNT, 3*COUNT instruction bytes, CHK), packs each byte triple into a
// 20-bit instruction and writes it to consecutive addresses from 0. The CPU
// is held for the whole load; a good checksum releases it with a one-cycle
// CPU reset pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_loader_if.slave (stream in, memory write out, CPU control)
module instr_loader #(
   parameter int ADDR_W = 5
) (
   input  logic           clk,
   input  logic           reset,
   instr_loader_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;  // holds 0..DEPTH inclusive

   typedef enum logic [3:0] {
      S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CHECK, S_DONE, S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             count_bad;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_n;
   logic [7:0]       chk;
   logic [7:0]       b0, b1;

   function automatic logic [19:0] pack_word(input logic [7:0] p0,
                                             input logic [7:0] p1,
                                             input logic [7:0] p2);
      return {p0[3:0], p1, p2};  // upper nibble of the first byte is dropped
   endfunction

   assign accept    = bus.byte_valid && bus.byte_ready;
   assign count_bad = (bus.byte_data == 8'd0) || (int'(bus.byte_data) > DEPTH);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.byte_ready = 1'b0;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_COUNT;
         S_COUNT: begin
            bus.byte_ready = 1'b1;
            if (accept) state_nxt = count_bad ? S_ERR : S_B0;
         end
         S_B0: begin
            bus.byte_ready = 1'b1;
            if (accept) state_nxt = S_B1;
         end
         S_B1: begin
            bus.byte_ready = 1'b1;
            if (accept) state_nxt = S_B2;
         end
         S_B2: begin
            bus.byte_ready = 1'b1;
            if (accept) state_nxt = S_WRITE;
         end
         S_WRITE: state_nxt = (word_cnt + 1'b1 == word_n) ? S_CHECK : S_B0;
         S_CHECK: begin
            bus.byte_ready = 1'b1;
            if (accept) state_nxt = (bus.byte_data == chk) ? S_DONE : S_ERR;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Byte holding registers carry no control meaning, so they are not reset.
   always_ff @(posedge clk) begin
      if (state == S_COUNT && accept) word_n <= bus.byte_data[CNT_W-1:0];
      if (state == S_B0 && accept)    b0     <= bus.byte_data;
      if (state == S_B1 && accept)    b1     <= bus.byte_data;
   end

   // Write port and CPU outputs are registered on the accepting edge so the
   // write lands in the WRITE cycle and the release lands in the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wr_en         <= 1'b0;
         bus.wr_addr       <= '0;
         bus.wr_data       <= '0;
         bus.cpu_hold      <= 1'b0;
         bus.cpu_rst_pulse <= 1'b0;
         bus.load_done     <= 1'b0;
         bus.load_err      <= 1'b0;
         word_cnt          <= '0;
         chk               <= '0;
      end else begin
         bus.wr_en         <= 1'b0;
         bus.cpu_rst_pulse <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) begin
               bus.load_done <= 1'b0;
               bus.load_err  <= 1'b0;
               bus.cpu_hold  <= 1'b1;
               word_cnt      <= '0;
               chk           <= '0;
            end
            S_COUNT: if (accept) chk <= bus.byte_data;
            S_B0, S_B1: if (accept) chk <= chk ^ bus.byte_data;
            S_B2: if (accept) begin
               chk         <= chk ^ bus.byte_data;
               bus.wr_en   <= 1'b1;
               bus.wr_addr <= word_cnt[ADDR_W-1:0];
               bus.wr_data <= pack_word(b0, b1, bus.byte_data);
            end
            S_WRITE: word_cnt <= word_cnt + 1'b1;
            S_CHECK: if (accept && bus.byte_data == chk) begin
               bus.cpu_hold      <= 1'b0;
               bus.cpu_rst_pulse <= 1'b1;
               bus.load_done     <= 1'b1;
            end
            S_ERR: bus.load_err <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   wr_count = 0;
   int   rst_pulses = 0;
   logic [24:0] sb_q[$];       // {addr, data} expected writes
   logic [7:0]  frame_q[$];    // instruction bytes of the next frame
   logic [7:0]  saved_q[$];

   instr_loader_if #(.ADDR_W(ADDR_W)) bus();

   instr_loader #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard side: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.cpu_rst_pulse === 1'b1) rst_pulses++;
      if (bus.wr_en === 1'b1) begin
         wr_count++;
         check("ready_low_on_write", {31'd0, bus.byte_ready}, 32'd0);
         if (sb_q.size() == 0) check("unexpected_write", {7'd0, bus.wr_addr, bus.wr_data}, 32'd0);
         else begin
            logic [24:0] e;
            e = sb_q.pop_front();
            check("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e[24:20]});
            check("wr_data", {12'd0, bus.wr_data}, {12'd0, e[19:0]});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic start_load();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hold_after_start", {31'd0, bus.cpu_hold}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit rdy;
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            bus.start      = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            bus.start = 1'b0;
         end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      n = 0;
      do begin
         @(negedge clk); rdy = bus.byte_ready;
         @(posedge clk); #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) check("accept_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
   endtask

   // Sends COUNT, the bytes in frame_q, then CHK (computed unless forced).
   task automatic run_frame(input logic [7:0] cnt, input bit force_chk,
                            input logic [7:0] chk_force, input bit gaps);
      logic [7:0] x;
      logic [7:0] w0, w1;
      bit good;
      int wr0, rp0;
      wr0 = wr_count;
      rp0 = rst_pulses;
      x = cnt;
      start_load();
      send_byte(cnt, gaps);
      if (cnt == 0 || cnt > 32) begin
         @(posedge clk); #1;
         check("err_badcount", {31'd0, bus.load_err}, 32'd1);
         check("hold_badcount", {31'd0, bus.cpu_hold}, 32'd1);
         check("writes_badcount", wr_count - wr0, 32'd0);
         return;
      end
      for (int i = 0; i < frame_q.size(); i++) begin
         if (i % 3 == 0) w0 = frame_q[i];
         if (i % 3 == 1) w1 = frame_q[i];
         if (i % 3 == 2) sb_q.push_back({5'(i / 3), w0[3:0], w1, frame_q[i]});
         x = x ^ frame_q[i];
         send_byte(frame_q[i], gaps);
      end
      good = !force_chk || (chk_force == x);
      send_byte(force_chk ? chk_force : x, gaps);
      if (good) begin
         check("rst_pulse", {31'd0, bus.cpu_rst_pulse}, 32'd1);
         check("hold_released", {31'd0, bus.cpu_hold}, 32'd0);
         check("load_done", {31'd0, bus.load_done}, 32'd1);
         check("load_err_clear", {31'd0, bus.load_err}, 32'd0);
         @(posedge clk); #1;
         check("rst_pulse_one_cycle", {31'd0, bus.cpu_rst_pulse}, 32'd0);
      end else begin
         @(posedge clk); #1;
         check("err_badchk", {31'd0, bus.load_err}, 32'd1);
         check("hold_badchk", {31'd0, bus.cpu_hold}, 32'd1);
         check("no_pulse_badchk", rst_pulses - rp0, 32'd0);
      end
      check("write_count", wr_count - wr0, frame_q.size() / 3);
      check("sb_empty", sb_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
      check({tag, "_wr_addr"}, {27'd0, bus.wr_addr}, 32'd0);
      check({tag, "_wr_data"}, {12'd0, bus.wr_data}, 32'd0);
      check({tag, "_hold"}, {31'd0, bus.cpu_hold}, 32'd0);
      check({tag, "_pulse"}, {31'd0, bus.cpu_rst_pulse}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.load_done}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.load_err}, 32'd0);
      check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: single word
      frame_q = '{8'h05, 8'hA3, 8'h7C};
      run_frame(8'h01, 1'b1, 8'hDB, 1'b0);

      // 2: full depth, back-to-back
      frame_q.delete();
      for (int i = 0; i < 96; i++) frame_q.push_back(8'($urandom));
      saved_q = frame_q;
      run_frame(8'd32, 1'b0, 8'h00, 1'b0);

      // 3: illegal counts
      frame_q.delete();
      run_frame(8'h00, 1'b0, 8'h00, 1'b0);
      run_frame(8'h21, 1'b0, 8'h00, 1'b0);

      // 4: bad checksum
      frame_q = '{8'h05, 8'hA3, 8'h7C};
      run_frame(8'h01, 1'b1, 8'h00, 1'b0);

      // 5: reset after second word of a 4-word load
      start_load();
      send_byte(8'h04, 1'b0);
      frame_q = '{8'h01, 8'h11, 8'h22, 8'h02, 8'h33, 8'h44};
      sb_q.push_back({5'd0, 20'h11122});
      sb_q.push_back({5'd1, 20'h23344});
      foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      check("midreset_sb_empty", sb_q.size(), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      frame_q = '{8'hF9, 8'h0B, 8'hAD};
      run_frame(8'h01, 1'b0, 8'h00, 1'b0);

      // 6: gaps and stray starts, same data as the full-depth run
      frame_q = saved_q;
      run_frame(8'd32, 1'b0, 8'h00, 1'b1);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
